branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequencer for the branch datapath. It takes the taken/not-taken result (b_sel) from the branch comparator in EX, plus the decoded branch/jump flags and the target address.
- It produces a registered PC redirect with a fetch handshake, timed IF/ID flush pulses, a misalignment error, and branch statistics counters.
- Sits between the EX stage and the fetch unit. It is the only source of control-flow redirects to fetch.

Parameters:
- XLEN, 32, width of PC and target addresses
- CNT_W, 32, width of the branch statistics counters (wrap at 2^CNT_W)
- FLUSH_CYCLES, 2, minimum cycles flush_if is held after a redirect issues (legal range 1..15)

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  EX holds a valid instruction this cycle
- ex_stall  input  1  EX frozen; the resolution is not sampled while high
- ex_is_branch  input  1  EX instruction is a conditional branch
- ex_is_jump  input  1  EX instruction is JAL/JALR (unconditionally taken)
- b_sel  input  1  comparator result; 1 = condition true
- ex_target  input  XLEN  computed branch/jump target
- if_ready  input  1  fetch accepts redirect_pc this cycle
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  XLEN  new fetch PC
- flush_if  output  1  squash the IF-stage instruction
- flush_id  output  1  squash the ID-stage instruction
- misalign_err  output  1  one-cycle pulse: taken target not 4-byte aligned
- busy  output  1  state != IDLE
- br_count  output  CNT_W  resolved conditional branches
- br_taken_count  output  CNT_W  taken conditional branches

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, every output=0, flush counter=0. A reset mid-redirect abandons the redirect with no further pulses.
- Resolution event "res":
  - Defined as ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump) & state==IDLE.
  - "take" = res & (ex_is_jump | (ex_is_branch & b_sel)). If ex_is_branch and ex_is_jump are both high, ex_is_jump wins.
- Counters:
  - On res with ex_is_branch & ~ex_is_jump: br_count+1.
  - If that branch is also taken: br_taken_count+1.
  - Counters wrap modulo 2^CNT_W and are not cleared except by rst.
- Misalignment: take with ex_target[1:0]!=0 causes:
  - misalign_err=1 on the next cycle only;
  - no redirect and no flush;
  - state stays IDLE.
  - The counters still update.
- States and transitions:
  - IDLE → REDIRECT on an aligned take. Registered on the same edge: redirect_pc = ex_target, flush counter = FLUSH_CYCLES.
  - In REDIRECT, redirect_valid=1 and redirect_pc is held stable.
  - In the first REDIRECT cycle, flush_id=1 for exactly that cycle.
  - flush_if=1 in every REDIRECT cycle, and additionally until the flush counter reaches 0.
  - REDIRECT → DRAIN when if_ready=1. The handshake completes in that cycle, and redirect_valid drops on the next cycle.
  - DRAIN: flush_if=1 while the flush counter is nonzero. The counter decrements every cycle from the REDIRECT entry onward, saturating at 0.
  - DRAIN → IDLE when the counter reaches 0 (flush_if=0 in the IDLE cycle). If the counter is already 0 at handshake, REDIRECT → IDLE directly.
- Latency: take at edge N gives redirect_valid and flush_id high in cycle N+1. With if_ready=1 in cycle N+1, redirect_valid is low in cycle N+2.
- Simultaneous events:
  - Resolutions arriving while busy=1 are wrong-path. They are ignored, not counted, and raise no misalign_err.
  - ex_stall=1 with a pending branch means no sampling. The branch is sampled in the first cycle ex_stall=0.
  - if_ready low indefinitely holds REDIRECT, with redirect_valid, redirect_pc and flush_if held.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package (cpu_pkg):
  - state enum {IDLE, REDIRECT, DRAIN}, 2 bits;
  - XLEN constant;
  - branch funct3 codes used by the comparator, 3'b000 BEQ, 3'b001 BNE, 3'b100 BLT, 3'b101 BGE, 3'b110 BLTU, 3'b111 BGEU, so decode and bench share them.
- One natural sub-module: branch_stat_counters, holding the two wrapping counters with increment enables. The FSM and flush counter stay in the top.

Test Plan:
- Not-taken branch: ex_is_branch=1, b_sel=0, ex_target=0x100 → no redirect, no flush; br_count=1, br_taken_count=0.
- Taken branch with fetch ready: b_sel=1, ex_target=0x0000_0200, if_ready=1 → cycle N+1 has redirect_valid=1, redirect_pc=0x200, flush_id=1, flush_if=1. flush_if stays high 2 cycles total (FLUSH_CYCLES=2), then IDLE. br_taken_count=1.
- Fetch backpressure: taken JAL to 0x400 with if_ready=0 for 5 cycles → redirect_valid and flush_if held for 5 cycles with redirect_pc=0x400. A second branch presented during the hold is ignored (br_count unchanged). Handshake on cycle 6, then IDLE.
- Misaligned: ex_is_jump=1, ex_target=0x0000_0102 → misalign_err pulse for 1 cycle; redirect_valid stays 0; busy stays 0.
- Stall and reset: branch held with ex_stall=1 for 3 cycles → no counter change until ex_stall=0. Then assert rst during REDIRECT → next cycle all outputs 0 and busy=0.
- Counter wrap (CNT_W=4): 16 taken branches → br_count and br_taken_count return to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: redirect FSM state encoding, XLEN and branch funct3 codes.
`default_nettype none

package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } redirect_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

`default_nettype wire

// File: rtl/branch_stat_counters.sv
// Wrapping counters for resolved and taken conditional branches.
`default_nettype none

module branch_stat_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_br,
  input  logic             inc_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else begin
      if (inc_br)    br_count       <= br_count + 1'b1;
      if (inc_taken) br_taken_count <= br_taken_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer: registered PC redirect with fetch handshake,
// timed IF/ID flush, misalignment error and branch statistics.
`default_nettype none

module branch_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             b_sel,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             if_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             misalign_err,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  redirect_state_t state, state_next;
  logic [3:0]      flush_cnt, flush_cnt_next;
  logic [XLEN-1:0] redirect_pc_next;
  logic            flush_id_next, misalign_next;
  logic            res, take, aligned, inc_br, inc_taken;

  // Only IDLE samples a resolution; anything seen while busy is wrong-path.
  assign res       = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump) & (state == IDLE);
  assign take      = res & (ex_is_jump | (ex_is_branch & b_sel));
  assign aligned   = (ex_target[1:0] == 2'b00);
  assign inc_br    = res & ex_is_branch & ~ex_is_jump;
  assign inc_taken = inc_br & b_sel;

  always_comb begin
    state_next       = state;
    flush_cnt_next   = (flush_cnt != 4'd0) ? flush_cnt - 4'd1 : 4'd0;
    redirect_pc_next = redirect_pc;
    flush_id_next    = 1'b0;
    misalign_next    = take & ~aligned;
    case (state)
      IDLE: begin
        if (take && aligned) begin
          state_next       = REDIRECT;
          flush_cnt_next   = FLUSH_INIT;
          redirect_pc_next = ex_target;
          flush_id_next    = 1'b1;
        end
      end
      REDIRECT: begin
        if (if_ready) state_next = (flush_cnt_next == 4'd0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (flush_cnt_next == 4'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flush_cnt    <= 4'd0;
      redirect_pc  <= '0;
      flush_id     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      flush_cnt    <= flush_cnt_next;
      redirect_pc  <= redirect_pc_next;
      flush_id     <= flush_id_next;
      misalign_err <= misalign_next;
    end
  end

  // Decoded purely from registers, so no input reaches an output combinationally.
  assign redirect_valid = (state == REDIRECT);
  assign flush_if       = (state == REDIRECT) | (flush_cnt != 4'd0);
  assign busy           = (state != IDLE);

  branch_stat_counters #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk           (clk),
    .rst           (rst),
    .inc_br        (inc_br),
    .inc_taken     (inc_taken),
    .br_count      (br_count),
    .br_taken_count(br_taken_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// Table-driven, scoreboarded bench for branch_redirect_ctrl (CNT_W=4, FLUSH_CYCLES=2).
`default_nettype none

module tb_branch_redirect_ctrl;
  import cpu_pkg::*;

  localparam int CW = 4;

  typedef struct {
    logic            rst, v, st, br, jp, bs;
    logic [XLEN-1:0] tgt;
    logic            rdy;
    logic            e_rv;
    logic [XLEN-1:0] e_pc;
    logic            e_fif, e_fid, e_mis, e_busy;
    int              e_brc, e_tkc;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ex_valid = 1'b0, ex_stall = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0, b_sel = 1'b0;
  logic [XLEN-1:0] ex_target = '0;
  logic            if_ready = 1'b0;
  logic            redirect_valid, flush_if, flush_id, misalign_err, busy;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   br_count, br_taken_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .XLEN(XLEN), .CNT_W(CW), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .b_sel(b_sel),
    .ex_target(ex_target), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .misalign_err(misalign_err),
    .busy(busy), .br_count(br_count), .br_taken_count(br_taken_count)
  );

  function automatic vec_t row(logic r, logic v, logic st, logic br, logic jp, logic bs,
                               logic [XLEN-1:0] tgt, logic rdy, logic e_rv, logic [XLEN-1:0] e_pc,
                               logic e_fif, logic e_fid, logic e_mis, logic e_busy,
                               int e_brc, int e_tkc);
    vec_t x;
    x.rst = r; x.v = v; x.st = st; x.br = br; x.jp = jp; x.bs = bs; x.tgt = tgt; x.rdy = rdy;
    x.e_rv = e_rv; x.e_pc = e_pc; x.e_fif = e_fif; x.e_fid = e_fid; x.e_mis = e_mis;
    x.e_busy = e_busy; x.e_brc = e_brc % 16; x.e_tkc = e_tkc % 16;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Inputs are driven just after an edge; the expected outputs for the next edge are queued.
  task automatic apply(input vec_t x, input int idx);
    vec_t e;
    rst = x.rst; ex_valid = x.v; ex_stall = x.st; ex_is_branch = x.br;
    ex_is_jump = x.jp; b_sel = x.bs; ex_target = x.tgt; if_ready = x.rdy;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("redirect_valid", idx, XLEN'(redirect_valid), XLEN'(e.e_rv));
    chk("redirect_pc",    idx, redirect_pc,           e.e_pc);
    chk("flush_if",       idx, XLEN'(flush_if),       XLEN'(e.e_fif));
    chk("flush_id",       idx, XLEN'(flush_id),       XLEN'(e.e_fid));
    chk("misalign_err",   idx, XLEN'(misalign_err),   XLEN'(e.e_mis));
    chk("busy",           idx, XLEN'(busy),           XLEN'(e.e_busy));
    chk("br_count",       idx, XLEN'(br_count),       XLEN'(e.e_brc));
    chk("br_taken_count", idx, XLEN'(br_taken_count), XLEN'(e.e_tkc));
  endtask

  initial begin
    //                r  v  st br jp bs tgt        rdy rv pc         fif fid mis busy brc tkc
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h0,     0,  0,  0,  0,   0,  0));
    tbl.push_back(row(1, 1, 0, 1, 0, 1, 32'h80,    1,  0, 32'h0,     0,  0,  0,  0,   0,  0));
    // not-taken branch
    tbl.push_back(row(0, 1, 0, 1, 0, 0, 32'h100,   1,  0, 32'h0,     0,  0,  0,  0,   1,  0));
    tbl.push_back(row(0, 0, 0, 1, 0, 1, 32'h104,   1,  0, 32'h0,     0,  0,  0,  0,   1,  0));
    // taken branch, fetch ready
    tbl.push_back(row(0, 1, 0, 1, 0, 1, 32'h200,   1,  1, 32'h200,   1,  1,  0,  1,   2,  1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h200,   1,  0,  0,  1,   2,  1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h200,   0,  0,  0,  0,   2,  1));
    // JAL with fetch backpressure; wrong-path branch during hold
    tbl.push_back(row(0, 1, 0, 0, 1, 0, 32'h400,   0,  1, 32'h400,   1,  1,  0,  1,   2,  1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     0,  1, 32'h400,   1,  0,  0,  1,   2,  1));
    tbl.push_back(row(0, 1, 0, 1, 0, 1, 32'h301,   0,  1, 32'h400,   1,  0,  0,  1,   2,  1));
    tbl.push_back(row(0, 1, 0, 1, 0, 0, 32'h300,   0,  1, 32'h400,   1,  0,  0,  1,   2,  1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     0,  1, 32'h400,   1,  0,  0,  1,   2,  1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     0,  1, 32'h400,   1,  0,  0,  1,   2,  1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h400,   0,  0,  0,  0,   2,  1));
    // misaligned jump, then misaligned taken branch (still counted)
    tbl.push_back(row(0, 1, 0, 0, 1, 0, 32'h102,   1,  0, 32'h400,   0,  0,  1,  0,   2,  1));
    tbl.push_back(row(0, 1, 0, 1, 0, 1, 32'h201,   1,  0, 32'h400,   0,  0,  1,  0,   3,  2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h400,   0,  0,  0,  0,   3,  2));
    // branch and jump flags together: jump wins, not counted
    tbl.push_back(row(0, 1, 0, 1, 1, 0, 32'h500,   1,  1, 32'h500,   1,  1,  0,  1,   3,  2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h500,   1,  0,  0,  1,   3,  2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h500,   0,  0,  0,  0,   3,  2));
    // stalled branch sampled once stall drops, then reset mid-redirect
    tbl.push_back(row(0, 1, 1, 1, 0, 1, 32'h600,   0,  0, 32'h500,   0,  0,  0,  0,   3,  2));
    tbl.push_back(row(0, 1, 1, 1, 0, 1, 32'h600,   0,  0, 32'h500,   0,  0,  0,  0,   3,  2));
    tbl.push_back(row(0, 1, 1, 1, 0, 1, 32'h600,   0,  0, 32'h500,   0,  0,  0,  0,   3,  2));
    tbl.push_back(row(0, 1, 0, 1, 0, 1, 32'h600,   0,  1, 32'h600,   1,  1,  0,  1,   4,  3));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     0,  1, 32'h600,   1,  0,  0,  1,   4,  3));
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 32'h0,     0,  0, 32'h0,     0,  0,  0,  0,   0,  0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h0,     1,  0, 32'h0,     0,  0,  0,  0,   0,  0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Counter wrap: 16 aligned taken branches bring both 4-bit counters back to 0.
    for (int i = 0; i < 16; i++) begin
      logic [XLEN-1:0] t;
      t = 32'h1000 + XLEN'(i * 16);
      apply(row(0, 1, 0, 1, 0, 1, t, 1, 1, t, 1, 1, 0, 1, i + 1, i + 1), 100 + 3 * i);
      apply(row(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, t, 1, 0, 0, 1, i + 1, i + 1), 101 + 3 * i);
      apply(row(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, t, 0, 0, 0, 0, i + 1, i + 1), 102 + 3 * i);
    end
    chk("wrap_br_count", 200, XLEN'(br_count), XLEN'(0));
    chk("wrap_taken_count", 200, XLEN'(br_taken_count), XLEN'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
